// File: rtl/ntt_sched_pkg.sv
// Shared types and helpers for the NTT job scheduler: FSM state encoding,
// witness width and the round-robin pointer successor.
package ntt_sched_pkg;

    localparam int WITNESS_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_RESPOND
    } ntt_sched_state_t;

    // Index that follows the round-robin pointer, wrapping at num_req.
    function automatic int unsigned rr_next_idx(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at the requester
// after ptr and wraps; the caller registers the result.
module rr_arbiter
    import ntt_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [31:0] start_idx;
    logic [31:0] cand;

    assign start_idx = rr_next_idx(32'(ptr), NUM_REQ);

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start_idx + 32'(k);
            if (cand >= 32'(NUM_REQ)) begin
                cand = cand - 32'(NUM_REQ);
            end
            if (!grant_any && req[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Time-shares one NTT core among NUM_REQ requesters: round-robin grant,
// coefficient load, start pulse, watchdogged wait, tagged witness response.
module ntt_job_scheduler
    import ntt_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LOGN           = 8,
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_grant,
    input  logic [NUM_REQ-1:0]         in_coeff_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   in_coeff_data,
    output logic [NUM_REQ-1:0]         in_coeff_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_error,
    output logic [WITNESS_W-1:0]       rsp_witness,
    output logic                       core_coeff_valid,
    output logic [WIDTH-1:0]           core_coeff_data,
    output logic [LOGN-1:0]            core_coeff_addr,
    output logic                       core_start,
    input  logic                       core_busy,
    input  logic                       core_done,
    input  logic                       core_witness_valid,
    input  logic [WITNESS_W-1:0]       core_witness,
    output logic [CNT_WIDTH-1:0]       jobs_ok,
    output logic [CNT_WIDTH-1:0]       jobs_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    ntt_sched_state_t     state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [LOGN-1:0]      addr_q, addr_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 cc_valid_q, cc_valid_d;
    logic [WIDTH-1:0]     cc_data_q, cc_data_d;
    logic [LOGN-1:0]      cc_addr_q, cc_addr_d;
    logic                 start_q, start_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [WITNESS_W-1:0] rsp_witness_q, rsp_witness_d;
    logic [CNT_WIDTH-1:0] jobs_ok_q, jobs_ok_d;
    logic [CNT_WIDTH-1:0] jobs_err_q, jobs_err_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [WIDTH-1:0]     coeff_lane [NUM_REQ];
    logic                 beat;
    logic                 unused_inputs;

    // core_done adds nothing beyond core_witness_valid for this scheduler.
    assign unused_inputs = core_done;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign coeff_lane[gi] = in_coeff_data[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign beat = (state_q == ST_LOAD) && in_coeff_valid[gidx_q] && grant_q[gidx_q];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        wd_d          = wd_q;
        cc_valid_d    = 1'b0;
        cc_data_d     = cc_data_q;
        cc_addr_d     = cc_addr_q;
        start_d       = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_error_d   = rsp_error_q;
        rsp_witness_d = rsp_witness_q;
        jobs_ok_d     = jobs_ok_q;
        jobs_err_d    = jobs_err_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any && !core_busy) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    ptr_d   = arb_idx;
                    addr_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    cc_valid_d = 1'b1;
                    cc_data_d  = coeff_lane[gidx_q];
                    cc_addr_d  = addr_q;
                    addr_d     = addr_q + 1'b1;
                    if (addr_q == '1) begin
                        grant_d = '0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A witness on the last watchdog cycle still wins over the timeout.
                if (core_witness_valid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = gidx_q;
                    rsp_error_d   = 1'b0;
                    rsp_witness_d = core_witness;
                    state_d       = ST_RESPOND;
                end else if (wd_q == WD_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = gidx_q;
                    rsp_error_d   = 1'b1;
                    rsp_witness_d = '0;
                    state_d       = ST_RESPOND;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_error_q) begin
                        if (jobs_err_q != '1) jobs_err_d = jobs_err_q + 1'b1;
                    end else begin
                        if (jobs_ok_q != '1) jobs_ok_d = jobs_ok_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            gidx_q        <= '0;
            grant_q       <= '0;
            addr_q        <= '0;
            wd_q          <= '0;
            cc_valid_q    <= 1'b0;
            cc_data_q     <= '0;
            cc_addr_q     <= '0;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_error_q   <= 1'b0;
            rsp_witness_q <= '0;
            jobs_ok_q     <= '0;
            jobs_err_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            wd_q          <= wd_d;
            cc_valid_q    <= cc_valid_d;
            cc_data_q     <= cc_data_d;
            cc_addr_q     <= cc_addr_d;
            start_q       <= start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_error_q   <= rsp_error_d;
            rsp_witness_q <= rsp_witness_d;
            jobs_ok_q     <= jobs_ok_d;
            jobs_err_q    <= jobs_err_d;
        end
    end

    assign req_grant        = grant_q;
    assign in_coeff_ready   = (state_q == ST_LOAD) ? grant_q : '0;
    assign core_coeff_valid = cc_valid_q;
    assign core_coeff_data  = cc_data_q;
    assign core_coeff_addr  = cc_addr_q;
    assign core_start       = start_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_error        = rsp_error_q;
    assign rsp_witness      = rsp_witness_q;
    assign jobs_ok          = jobs_ok_q;
    assign jobs_err         = jobs_err_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Self-checking bench for ntt_job_scheduler: a job table plus randomized jobs
// scored against a queue/arithmetic model of the scheduler's rules.
module tb_ntt_job_scheduler;

    localparam int NR      = 4;
    localparam int LOGN    = 8;
    localparam int N       = 1 << LOGN;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 1024;
    localparam int CW      = 16;

    logic                 clk;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_grant;
    logic [NR-1:0]        in_coeff_valid;
    logic [NR*WIDTH-1:0]  in_coeff_data;
    logic [NR-1:0]        in_coeff_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic                 rsp_error;
    logic [255:0]         rsp_witness;
    logic                 core_coeff_valid;
    logic [WIDTH-1:0]     core_coeff_data;
    logic [LOGN-1:0]      core_coeff_addr;
    logic                 core_start;
    logic                 core_busy;
    logic                 core_done;
    logic                 core_witness_valid;
    logic [255:0]         core_witness;
    logic [CW-1:0]        jobs_ok;
    logic [CW-1:0]        jobs_err;

    ntt_job_scheduler #(
        .NUM_REQ(NR), .LOGN(LOGN), .WIDTH(WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_grant(req_grant),
        .in_coeff_valid(in_coeff_valid), .in_coeff_data(in_coeff_data),
        .in_coeff_ready(in_coeff_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_error(rsp_error), .rsp_witness(rsp_witness),
        .core_coeff_valid(core_coeff_valid), .core_coeff_data(core_coeff_data),
        .core_coeff_addr(core_coeff_addr), .core_start(core_start),
        .core_busy(core_busy), .core_done(core_done),
        .core_witness_valid(core_witness_valid), .core_witness(core_witness),
        .jobs_ok(jobs_ok), .jobs_err(jobs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;
        int            gap;
        int            lat;
        int            stall;
        int            busy_hold;
        bit            seq;
        int            exp_id;
        bit            exp_err;
    } job_vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int starts = 0;
    int writes = 0;
    int last_g = NR - 1;
    int m_ok = 0;
    int m_err = 0;
    int job_no = 0;
    bit prev_rsp_valid = 1'b0;
    logic [263:0] prev_rsp = '0;
    logic [LOGN+WIDTH-1:0] exp_q[$];
    job_vec_t tbl [9];

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first requester found after the last granted one.
    function automatic int model_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        bit r_edge;
        logic [LOGN+WIDTH-1:0] e;
        r_edge = rsp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            prev_rsp_valid = 1'b0;
        end else begin
            if (core_coeff_valid) begin
                writes++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("core_write", {core_coeff_addr, core_coeff_data}, e);
                end
                last_wr_cyc = cyc;
            end
            if (core_start) begin
                starts++;
                chk("start_after_last_write", cyc, last_wr_cyc + 1);
            end
            if (prev_rsp_valid && !r_edge)
                chk("rsp_hold", {rsp_valid, rsp_id, rsp_error, rsp_witness}, prev_rsp);
            prev_rsp_valid = rsp_valid;
            prev_rsp = {rsp_valid, rsp_id, rsp_error, rsp_witness};
        end
    endtask

    task automatic stream(input int g, input int nb, input int gap, input bit seq);
        int i;
        int guard;
        logic [WIDTH-1:0] d;
        bit v;
        i = 0;
        guard = 0;
        while (i < nb && guard < 8 * N) begin
            v = ($urandom_range(99) >= gap);
            d = seq ? WIDTH'(i) : WIDTH'($urandom);
            for (int l = 0; l < NR; l++) begin
                in_coeff_data[l*WIDTH +: WIDTH] = WIDTH'($urandom);
                in_coeff_valid[l] = 1'($urandom_range(1));
            end
            in_coeff_valid[g] = v;
            in_coeff_data[g*WIDTH +: WIDTH] = d;
            chk("coeff_ready", in_coeff_ready, 1 << g);
            if (v && in_coeff_ready[g]) begin
                exp_q.push_back({LOGN'(i), d});
                i++;
            end
            step();
            guard++;
        end
        in_coeff_valid = '0;
        chk("load_beats", i, nb);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, {req_grant, in_coeff_ready}, 0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_error, rsp_witness}, 0);
        chk({tag, "_core"}, {core_coeff_valid, core_coeff_data, core_coeff_addr, core_start}, 0);
        chk({tag, "_counters"}, {jobs_ok, jobs_err}, 0);
    endtask

    task automatic do_job(input logic [NR-1:0] mask, input int gap, input int lat,
                          input int stall, input int busy_hold, input bit seq,
                          input int exp_id, input bit exp_err, input logic [255:0] wit);
        int rsp_step;
        starts = 0;
        writes = 0;
        req_valid = mask;
        for (int k = 0; k < busy_hold; k++) begin
            step();
            chk("grant_blocked_busy", req_grant, 0);
        end
        core_busy = 1'b0;
        step();
        chk("grant", req_grant, 1 << exp_id);
        req_valid = '0;
        stream(exp_id, N, gap, seq);
        chk("grant_drop", {req_grant, in_coeff_ready}, 0);
        step();
        chk("core_start", core_start, 1);
        core_busy = 1'b1;
        rsp_step = exp_err ? TIMEOUT : lat + 1;
        for (int k = 0; k < rsp_step; k++) begin
            core_witness_valid = (k == lat);
            core_done = (k == lat);
            core_witness = (k == lat) ? wit : {8{$urandom}};
            if (k == rsp_step - 1) chk("rsp_early", rsp_valid, 0);
            step();
            if (k == lat) core_busy = 1'b0;
        end
        core_witness_valid = 1'b0;
        core_done = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_error", rsp_error, exp_err);
        chk("rsp_witness", rsp_witness, exp_err ? 256'd0 : wit);
        if (lat >= rsp_step) begin
            core_witness_valid = 1'b1;
            core_done = 1'b1;
            core_witness = wit;
            step();
            core_witness_valid = 1'b0;
            core_done = 1'b0;
            core_busy = 1'b0;
        end
        for (int k = 0; k < stall; k++) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_release", rsp_valid, 0);
        if (exp_err) m_err++; else m_ok++;
        chk("jobs_ok", jobs_ok, m_ok);
        chk("jobs_err", jobs_err, m_err);
        chk("job_writes", writes, N);
        chk("job_starts", starts, 1);
        last_g = exp_id;
        $display("job %0d: mask=%b id=%0d err=%0d witness=%h", job_no, mask, exp_id, exp_err, wit);
        job_no++;
    endtask

    initial begin
        logic [NR-1:0] m;
        int eid;

        rst = 1'b1;
        req_valid = '0;
        in_coeff_valid = '0;
        in_coeff_data = '0;
        rsp_ready = 1'b0;
        core_busy = 1'b0;
        core_done = 1'b0;
        core_witness_valid = 1'b0;
        core_witness = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b0;

        // Single job from requester 2 with coefficients 0..N-1.
        do_job(4'b0100, 0, 20, 0, 0, 1'b1, 2, 1'b0, {8{32'hA5C3_0F17}});

        // Reset in the middle of a LOAD at beat 100.
        req_valid = 4'b0010;
        step();
        chk("mid_grant", req_grant, 4'b0010);
        req_valid = '0;
        stream(1, 100, 0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_load");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        prev_rsp_valid = 1'b0;
        last_g = NR - 1;
        m_ok = 0;
        m_err = 0;

        tbl[0] = '{4'hF,  0,    0,  0, 0, 1'b0, 0, 1'b0};
        tbl[1] = '{4'hF, 30,    7, 10, 0, 1'b0, 1, 1'b0};
        tbl[2] = '{4'hF,  0,   30,  3, 0, 1'b0, 2, 1'b0};
        tbl[3] = '{4'hF, 50,    3,  0, 0, 1'b0, 3, 1'b0};
        tbl[4] = '{4'hF, 10,   15, 10, 0, 1'b0, 0, 1'b0};
        tbl[5] = '{4'h4, 20,   -1,  2, 0, 1'b0, 2, 1'b1};
        tbl[6] = '{4'h8,  0, 1023,  0, 6, 1'b0, 3, 1'b0};
        tbl[7] = '{4'h3,  0, 1024,  4, 0, 1'b0, 0, 1'b1};
        tbl[8] = '{4'h6, 25,   12,  1, 0, 1'b0, 1, 1'b0};
        for (int t = 0; t < 9; t++) begin
            do_job(tbl[t].mask, tbl[t].gap, tbl[t].lat, tbl[t].stall, tbl[t].busy_hold,
                   tbl[t].seq, tbl[t].exp_id, tbl[t].exp_err, {8{$urandom}});
        end

        for (int r = 0; r < 5; r++) begin
            m = NR'($urandom_range(1, (1 << NR) - 1));
            eid = model_pick(m, last_g);
            do_job(m, $urandom_range(0, 50), $urandom_range(0, 60), $urandom_range(0, 12),
                   0, 1'b0, eid, 1'b0, {8{$urandom}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_job_scheduler.md
# ntt_job_scheduler

Job scheduler that time-shares one `parallel_ntt_core` between `NUM_REQ` packet-attestation requesters. It grants the core round-robin and streams the granted requester's N coefficients into core memory. It then pulses `core_start`, waits for the witness under a watchdog, and returns the 256-bit witness (or an error) tagged with the requester ID. It sits between the per-channel attestation front-ends and the single NTT core instance.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `LOGN`, default 8: log2 of polynomial length; N = 1<<LOGN.
- `WIDTH`, default 16: coefficient width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT_DONE.
- `CNT_WIDTH`, default 16: statistics counter width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester job request; level, held until granted.
- `req_grant`  out  NUM_REQ  one-hot; high for the whole LOAD phase of the granted requester.
- `in_coeff_valid`  in  NUM_REQ  per-requester coefficient beat valid.
- `in_coeff_data`  in  NUM_REQ*WIDTH  requester i at `[i*WIDTH +: WIDTH]`.
- `in_coeff_ready`  out  NUM_REQ  high only for the granted requester, in LOAD.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the response.
- `rsp_error`  out  1  1 = watchdog timeout.
- `rsp_witness`  out  256  witness; 0 when `rsp_error`=1.
- `core_coeff_valid`  out  1  core memory write strobe.
- `core_coeff_data`  out  WIDTH  write data.
- `core_coeff_addr`  out  LOGN  write address.
- `core_start`  out  1  one-cycle start pulse.
- `core_busy`  in  1  core busy.
- `core_done`  in  1  core done pulse.
- `core_witness_valid`  in  1  witness valid pulse.
- `core_witness`  in  256  witness data.
- `jobs_ok`  out  CNT_WIDTH  saturating count of successful responses.
- `jobs_err`  out  CNT_WIDTH  saturating count of error responses.

## Operation
- FSM states: IDLE, LOAD, START, WAIT_DONE, RESPOND.
- **IDLE:** if any `req_valid` is high and `core_busy`=0, pick the winner round-robin. The search starts at the requester after the last one granted. Register `req_grant`, clear the address counter, then go to LOAD.
- **LOAD:** a beat is accepted when `in_coeff_valid[g]` and `in_coeff_ready[g]` are both high.
  - Each accepted beat registers `core_coeff_valid`=1, `core_coeff_data`=beat, `core_coeff_addr`=counter, then increments the counter.
  - The requester may stall indefinitely; there is no LOAD timeout.
  - After the beat at address N-1, go to START and drop the grant.
- **START:** `core_start`<=1 for exactly one cycle, clear the watchdog, go to WAIT_DONE.
- **WAIT_DONE:**
  - On `core_witness_valid`, capture `core_witness` into `rsp_witness`, set `rsp_error`=0, go to RESPOND.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 without `core_witness_valid`, set `rsp_error`=1, `rsp_witness`=0, go to RESPOND.
  - If `core_witness_valid` arrives on that same cycle, capture it and report no error.
- **RESPOND:** hold `rsp_valid`, `rsp_id`, `rsp_error` and `rsp_witness` stable until `rsp_ready`. On handshake, increment `jobs_ok` or `jobs_err` (saturating at all-ones), then go to IDLE.
- A late `core_done` or `core_witness_valid` outside WAIT_DONE is ignored. The next grant still waits for `core_busy`=0.
- Requests that arrive while the FSM is not in IDLE are held by the requester and are not queued internally.

## Timing
- Reset (asynchronous, any state, including mid-LOAD or mid-WAIT):
  - All outputs go to 0.
  - State goes to IDLE.
  - The round-robin pointer goes to NUM_REQ-1, so requester 0 wins first.
- Grant latency: `req_grant` is high in the cycle after IDLE samples the request.
- Load: N cycles minimum with continuous valid. `core_coeff_*` lags the accepted beat by one cycle.
- Start: the last beat is accepted at edge k, so `core_coeff_valid` for address N-1 is high in cycle k. `core_start` is high in cycle k+1, after the core has taken the final write.
- Response: `rsp_valid` rises the cycle after the witness is captured or the watchdog fires.
- Minimum job: 1 + N + 1 + core latency + 1 + response-accept cycles.

## Structure
- Package `ntt_sched_pkg`:
  - state enum `ntt_sched_state_t`;
  - `WITNESS_W` = 256;
  - a function for the next index after the round-robin pointer.
- Sub-module `rr_arbiter` (parameterised NUM_REQ), combinational: inputs are the request vector and the pointer; outputs are the one-hot grant and its index. The scheduler registers the result.

## Test plan
- Single job: requester 2 streams coefficients 0..255 → addresses 0..255 written in order; one `core_start` one cycle after the last write; `rsp_id`=2; `rsp_witness` equals the core witness; `jobs_ok`=1.
- Contention: all 4 requesters hold `req_valid` → grants in order 0,1,2,3,0.
- Back-pressure: random `in_coeff_valid` gaps in LOAD and `rsp_ready` low for 10 cycles → no lost or duplicated writes; `rsp_*` stable while stalled.
- Timeout: core never asserts `core_witness_valid` → `rsp_error`=1, `rsp_witness`=0 after 1024 WAIT_DONE cycles; `jobs_err`=1; next grant waits for `core_busy`=0.
- Coincident events: `core_witness_valid` on the final watchdog cycle → `rsp_error`=0 with the witness captured.
- Reset: assert `rst` at beat 100 of a LOAD → all outputs 0 immediately; after release, requester 0 is granted first and the address restarts at 0.
